psola_playback: RTL and testbench
=================================

Name: psola_playback

Overview:
- Receiving end of the PSOLA output burst: consumes the 32-bit processed values, their addresses and the window length produced after each PSOLA pass.
- Buffers each window in a ping-pong pair of banks.
- Streams the window out as saturated signed 16-bit audio samples, one per audio-rate tick.
- Sits between the PSOLA/BRAM wrapper and the audio output path (DAC/PWM/I2S).

Parameters:
- MAX_EXTENDED, 2200, max processed window length (depth of each bank).
- FRAC_BITS, 8, arithmetic right shift applied to val_in before saturation.

Ports:
- clk_in  input  1  system clock
- rst_in  input  1  synchronous active-high reset
- window_len_in  input  $clog2(MAX_EXTENDED)  length L of the window about to be written
- window_len_valid_in  input  1  one-cycle strobe; window_len_in is valid; opens a fill
- val_in  input  32  processed sample value (signed)
- addr_in  input  $clog2(MAX_EXTENDED)  sample index within window
- valid_in  input  1  val_in/addr_in valid this cycle
- sample_tick_in  input  1  one-cycle audio-rate strobe, guaranteed >=4 cycles apart
- sample_out  output  16  signed output sample
- sample_valid_out  output  1  one-cycle strobe, sample_out valid
- underrun_out  output  1  one-cycle pulse, tick served with no data
- overflow_out  output  1  one-cycle pulse, window dropped (no free bank)
- playing_out  output  1  reader currently draining a bank

Behaviour:
- Storage: two banks of MAX_EXTENDED x 32 in a true-dual-port RAM, 2-cycle read latency. Port A is the write side; port B is the read side.
- Per bank: full flag and latched length len[b].
- Reset: all flags 0, both FSMs idle, read pointer 0, all outputs 0. Reset mid-fill or mid-play discards all buffered data. RAM contents are not cleared.
- Writer FSM, states W_IDLE and W_FILL:
  - window_len_valid_in with L==0: ignored, no state change.
  - window_len_valid_in with L>0 and a non-full bank present: select the lowest-index non-full bank not being read, latch len=L, go to W_FILL.
  - window_len_valid_in with no bank available: overflow_out pulses next cycle, stay/return W_IDLE, subsequent valid_in ignored.
  - In W_FILL, each valid_in with addr_in<L writes val_in. Writes with addr_in>=L are ignored.
  - A write with addr_in==L-1 sets full[b] on the next cycle and returns to W_IDLE. Writes are out-of-order tolerant; only L-1 commits.
  - A new window_len_valid_in during W_FILL abandons the current bank (stays non-full) and restarts the selection.
- Reader FSM, states R_IDLE and R_PLAY:
  - R_IDLE: on sample_tick_in, if a full bank exists (prefer the one committed first), start it at rd_ptr=0, go to R_PLAY, and serve this tick from it.
  - R_IDLE with no full bank: serve zero and pulse underrun_out.
  - R_PLAY: each tick reads rd_ptr, then rd_ptr+1. After reading len-1 the bank's full flag clears, rd_ptr returns to 0, and the reader switches to the other bank if full, else goes to R_IDLE.
  - A commit in the same cycle the reader frees its bank: the next tick is served from the new bank, no underrun.
- Latency: tick at cycle t gives sample_valid_out=1 at t+3 for exactly one cycle, every tick, including underrun ticks (sample_out=0).
- Conversion: x = val_in >>> FRAC_BITS (signed). x>32767 gives 32767; x<-32768 gives -32768; otherwise x[15:0].
- playing_out = (reader state == R_PLAY).
- A bank being read is never selected for writing.

Test Plan:
- Fill: window_len_valid_in L=4, writes addr 0..3 of vals 0x100,0x200,-0x100,0x7FFFFF00 (FRAC_BITS=8); then 4 ticks. Required: sample_out 1, 2, -1, 32767, each at tick+3, no underrun.
- Underrun: ticks after reset, no window. Required: sample_out=0, sample_valid_out and underrun_out pulse at t+3 and t+1 respectively per tick.
- Ping-pong: commit windows A (L=3) and B (L=2) before first tick; 5 ticks. Required: A0,A1,A2,B0,B1 in order; playing_out high throughout; 6th tick underruns.
- Overflow: both banks full, third window_len_valid_in. Required: overflow_out pulse; later writes do not corrupt A/B playback.
- Boundary: write addr_in=L (ignored); L=0 strobe ignored; commit coincident with last read of other bank gives a seamless switch.
- Reset mid-play: rst_in during R_PLAY. Required: outputs 0, flags clear, next tick underruns.

Source files
------------

// File: rtl/psola_playback.sv
// psola_playback: ping-pong window buffer between the PSOLA engine and the audio path.
// Windows arrive via RAM port A and drain one saturated 16-bit sample per audio tick via port B.
module psola_playback #(
    parameter int MAX_EXTENDED = 2200,
    parameter int FRAC_BITS    = 8
) (
    input  logic                            clk_in,
    input  logic                            rst_in,
    input  logic [$clog2(MAX_EXTENDED)-1:0] window_len_in,
    input  logic                            window_len_valid_in,
    input  logic [31:0]                     val_in,
    input  logic [$clog2(MAX_EXTENDED)-1:0] addr_in,
    input  logic                            valid_in,
    input  logic                            sample_tick_in,
    output logic [15:0]                     sample_out,
    output logic                            sample_valid_out,
    output logic                            underrun_out,
    output logic                            overflow_out,
    output logic                            playing_out
);
    localparam int AW = $clog2(MAX_EXTENDED);
    localparam int IW = $clog2(2 * MAX_EXTENDED);
    localparam logic [AW-1:0] ONE   = {{(AW-1){1'b0}}, 1'b1};
    localparam logic [AW:0]   DEPTH = (AW+1)'(MAX_EXTENDED);

    typedef enum logic {W_IDLE = 1'b0, W_FILL = 1'b1} w_state_t;
    typedef enum logic {R_IDLE = 1'b0, R_PLAY = 1'b1} r_state_t;

    w_state_t      w_state_r, w_state_nxt_s;
    r_state_t      r_state_r, r_state_nxt_s;

    logic [1:0]    full_r;
    logic [AW-1:0] len_r [2];
    logic          wr_bank_r;
    logic          rd_bank_r;
    logic          oldest_r;
    logic [AW-1:0] rd_ptr_r;

    logic [31:0]   mem [2*MAX_EXTENDED];
    logic [IW-1:0] rd_addr_r;
    logic [31:0]   rd_data_r;
    logic          v1_r, z1_r, v2_r, z2_r;

    logic          open_s, sel_ok_s, sel_bank_s, overflow_s;
    logic          wr_en_s, commit_s;
    logic          serve_s, last_s, underrun_s, cur_bank_s, other_full_s;
    logic [AW-1:0] cur_ptr_s;

    function automatic logic [IW-1:0] ram_idx(input logic bank, input logic [AW-1:0] a);
        return (bank ? IW'(MAX_EXTENDED) : {IW{1'b0}}) + IW'(a);
    endfunction

    function automatic logic [15:0] saturate(input logic [31:0] v);
        logic signed [31:0] x;
        x = $signed(v) >>> FRAC_BITS;
        if (x > 32'sd32767) begin
            return 16'h7FFF;
        end else if (x < -32'sd32768) begin
            return 16'h8000;
        end else begin
            return x[15:0];
        end
    endfunction

    // State registers for the writer and reader FSMs
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            w_state_r <= W_IDLE;
            r_state_r <= R_IDLE;
        end else begin
            w_state_r <= w_state_nxt_s;
            r_state_r <= r_state_nxt_s;
        end
    end

    // Decode strobes: bank selection, write/commit and which bank/pointer a tick is served from
    always_comb begin
        open_s = window_len_valid_in && (window_len_in != {AW{1'b0}});
        if (!full_r[0] && !(r_state_r == R_PLAY && rd_bank_r == 1'b0)) begin
            sel_ok_s   = 1'b1;
            sel_bank_s = 1'b0;
        end else if (!full_r[1] && !(r_state_r == R_PLAY && rd_bank_r == 1'b1)) begin
            sel_ok_s   = 1'b1;
            sel_bank_s = 1'b1;
        end else begin
            sel_ok_s   = 1'b0;
            sel_bank_s = 1'b0;
        end
        overflow_s = open_s && !sel_ok_s;
        // A zero-length strobe does not interrupt an ongoing fill
        wr_en_s  = (w_state_r == W_FILL) && valid_in && !open_s &&
                   (addr_in < len_r[wr_bank_r]) && ({1'b0, addr_in} < DEPTH);
        commit_s = wr_en_s && (addr_in == len_r[wr_bank_r] - ONE);

        if (r_state_r == R_PLAY) begin
            cur_bank_s = rd_bank_r;
            cur_ptr_s  = rd_ptr_r;
            serve_s    = sample_tick_in;
        end else begin
            cur_bank_s = (full_r == 2'b11) ? oldest_r : full_r[1];
            cur_ptr_s  = {AW{1'b0}};
            serve_s    = sample_tick_in && (full_r != 2'b00);
        end
        other_full_s = full_r[~cur_bank_s];
        last_s       = serve_s && (cur_ptr_s == len_r[cur_bank_s] - ONE);
        underrun_s   = sample_tick_in && !serve_s;
    end

    // Next-state logic for both FSMs
    always_comb begin
        w_state_nxt_s = w_state_r;
        case (w_state_r)
            W_IDLE: begin
                if (open_s && sel_ok_s) w_state_nxt_s = W_FILL;
                else                    w_state_nxt_s = W_IDLE;
            end
            W_FILL: begin
                if (open_s)        w_state_nxt_s = sel_ok_s ? W_FILL : W_IDLE;
                else if (commit_s) w_state_nxt_s = W_IDLE;
                else               w_state_nxt_s = W_FILL;
            end
            default: w_state_nxt_s = W_IDLE;
        endcase

        r_state_nxt_s = r_state_r;
        case (r_state_r)
            R_IDLE: begin
                if (serve_s) r_state_nxt_s = (last_s && !other_full_s) ? R_IDLE : R_PLAY;
                else         r_state_nxt_s = R_IDLE;
            end
            R_PLAY: begin
                if (last_s) r_state_nxt_s = other_full_s ? R_PLAY : R_IDLE;
                else        r_state_nxt_s = R_PLAY;
            end
            default: r_state_nxt_s = R_IDLE;
        endcase
    end

    // Bank bookkeeping, read pipeline control and registered outputs
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            full_r           <= 2'b00;
            len_r[0]         <= {AW{1'b0}};
            len_r[1]         <= {AW{1'b0}};
            wr_bank_r        <= 1'b0;
            rd_bank_r        <= 1'b0;
            oldest_r         <= 1'b0;
            rd_ptr_r         <= {AW{1'b0}};
            rd_addr_r        <= {IW{1'b0}};
            v1_r             <= 1'b0;
            z1_r             <= 1'b0;
            v2_r             <= 1'b0;
            z2_r             <= 1'b0;
            sample_out       <= 16'h0000;
            sample_valid_out <= 1'b0;
            underrun_out     <= 1'b0;
            overflow_out     <= 1'b0;
        end else begin
            if (open_s && sel_ok_s) begin
                wr_bank_r          <= sel_bank_s;
                len_r[sel_bank_s]  <= window_len_in;
            end
            // The other bank stays oldest unless it is being released in this same cycle
            if (commit_s) begin
                full_r[wr_bank_r] <= 1'b1;
                oldest_r <= (full_r[~wr_bank_r] && !(last_s && cur_bank_s == ~wr_bank_r)) ?
                            ~wr_bank_r : wr_bank_r;
            end
            if (last_s) begin
                full_r[cur_bank_s] <= 1'b0;
                rd_ptr_r           <= {AW{1'b0}};
                rd_bank_r          <= other_full_s ? ~cur_bank_s : cur_bank_s;
            end else if (serve_s) begin
                rd_ptr_r  <= cur_ptr_s + ONE;
                rd_bank_r <= cur_bank_s;
            end
            rd_addr_r        <= ram_idx(cur_bank_s, cur_ptr_s);
            v1_r             <= sample_tick_in;
            z1_r             <= underrun_s;
            v2_r             <= v1_r;
            z2_r             <= z1_r;
            sample_valid_out <= v2_r;
            sample_out       <= (v2_r && !z2_r) ? saturate(rd_data_r) : 16'h0000;
            underrun_out     <= underrun_s;
            overflow_out     <= overflow_s;
        end
    end

    // Dual-port sample RAM: port A writes, port B registered read (contents survive reset)
    always_ff @(posedge clk_in) begin
        if (wr_en_s) begin
            mem[ram_idx(wr_bank_r, addr_in)] <= val_in;
        end
        rd_data_r <= mem[rd_addr_r];
    end

    assign playing_out = (r_state_r == R_PLAY);

endmodule

// File: tb/tb_psola_playback.sv
// Randomized and directed bench for psola_playback against a queue-based window model.
module tb_psola_playback;
    localparam int MAXE = 2200;
    localparam int AW   = $clog2(MAXE);
    localparam int NMAX = 8192;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [AW-1:0] wl = '0;
    logic          wlv = 1'b0;
    logic [31:0]   val = '0;
    logic [AW-1:0] addr = '0;
    logic          vin = 1'b0;
    logic          tick = 1'b0;
    logic [15:0]   sample_out;
    logic          sample_valid_out, underrun_out, overflow_out, playing_out;

    psola_playback #(.MAX_EXTENDED(MAXE), .FRAC_BITS(8)) dut (
        .clk_in(clk), .rst_in(rst), .window_len_in(wl), .window_len_valid_in(wlv),
        .val_in(val), .addr_in(addr), .valid_in(vin), .sample_tick_in(tick),
        .sample_out(sample_out), .sample_valid_out(sample_valid_out),
        .underrun_out(underrun_out), .overflow_out(overflow_out), .playing_out(playing_out)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int n = 0;
    int last_tick = -100;

    // Reference model: banks hold whole windows; cq lists full banks oldest first
    logic [31:0] m_mem [int];
    int          m_len [2];
    int          cq [$];
    int          m_play = -1;
    int          m_ptr = 0;
    int          m_fill = -1;

    bit          e_vld [NMAX];
    bit          e_und [NMAX];
    bit          e_ovf [NMAX];
    bit          e_play [NMAX];
    logic [15:0] e_smp [NMAX];

    logic [15:0] got_q [$];
    logic [15:0] exp_q [$];
    int          und_seen = 0;
    int          ovf_seen = 0;
    int          u0, o0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, got, exp, n);
        end
    endtask

    function automatic logic [15:0] ref_sat(input logic [31:0] v);
        longint x;
        x = longint'($signed(v));
        x = (x >= 0) ? x / 256 : -((-x + 255) / 256);
        if (x > 32767) return 16'h7FFF;
        if (x < -32768) return 16'h8000;
        return 16'(x);
    endfunction

    function automatic bit in_q(input int b);
        foreach (cq[i]) if (cq[i] == b) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_edge();
        bit          old_full [2];
        int          old_play;
        int          commit_b;
        int          sel;
        int          L, a;
        logic [15:0] s;
        if (rst) begin
            cq.delete();
            m_play = -1; m_ptr = 0; m_fill = -1; m_len[0] = 0; m_len[1] = 0;
            for (int k = 0; k < 3; k++) begin
                e_vld[n+k] = 0; e_und[n+k] = 0; e_ovf[n+k] = 0; e_play[n+k] = 0; e_smp[n+k] = '0;
            end
            return;
        end
        old_play    = m_play;
        old_full[0] = in_q(0);
        old_full[1] = in_q(1);
        s = 16'h0000;
        e_und[n] = 0;
        if (tick) begin
            if (m_play < 0 && cq.size() > 0) begin
                m_play = cq[0];
                m_ptr  = 0;
            end
            if (m_play < 0) begin
                e_und[n] = 1;
            end else begin
                s = ref_sat(m_mem[m_play*4096 + m_ptr]);
                m_ptr++;
                if (m_ptr >= m_len[m_play]) begin
                    void'(cq.pop_front());
                    m_ptr  = 0;
                    m_play = (cq.size() > 0) ? cq[0] : -1;
                end
            end
        end
        commit_b = -1;
        e_ovf[n] = 0;
        L = int'(wl);
        a = int'(addr);
        if (wlv && L != 0) begin
            sel = -1;
            for (int b = 1; b >= 0; b--) if (!old_full[b] && b != old_play) sel = b;
            if (sel < 0) begin
                e_ovf[n] = 1;
                m_fill = -1;
            end else begin
                m_fill = sel;
                m_len[sel] = L;
            end
        end else if (m_fill >= 0 && vin && a < m_len[m_fill]) begin
            m_mem[m_fill*4096 + a] = val;
            if (a == m_len[m_fill] - 1) begin
                commit_b = m_fill;
                m_fill = -1;
            end
        end
        if (commit_b >= 0) cq.push_back(commit_b);
        e_play[n]  = (m_play >= 0);
        e_vld[n+2] = tick;
        e_smp[n+2] = s;
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
        check_val("valid", {31'd0, sample_valid_out}, {31'd0, e_vld[n]});
        check_val("underrun", {31'd0, underrun_out}, {31'd0, e_und[n]});
        check_val("overflow", {31'd0, overflow_out}, {31'd0, e_ovf[n]});
        check_val("playing", {31'd0, playing_out}, {31'd0, e_play[n]});
        if (e_vld[n]) check_val("sample", {16'd0, sample_out}, {16'd0, e_smp[n]});
        if (sample_valid_out) got_q.push_back(sample_out);
        if (underrun_out) und_seen++;
        if (overflow_out) ovf_seen++;
        if (tick) last_tick = n;
        n++;
        wlv = 1'b0; vin = 1'b0; tick = 1'b0;
    endtask

    task automatic open_win(input int L);
        wlv = 1'b1; wl = AW'(L); step();
    endtask

    task automatic wr(input int a, input logic [31:0] v);
        vin = 1'b1; addr = AW'(a); val = v; step();
    endtask

    task automatic tk();
        tick = 1'b1; step();
        repeat (3) step();
    endtask

    task automatic cmp_seq(input string tag);
        check_val({tag, "_count"}, got_q.size(), exp_q.size());
        foreach (exp_q[i]) if (i < got_q.size()) check_val(tag, {16'd0, got_q[i]}, {16'd0, exp_q[i]});
        got_q.delete();
    endtask

    initial begin
        // Reset, then seed both banks so every address the bench reads holds known data
        repeat (2) step();
        rst = 1'b0;
        for (int b = 0; b < 2; b++) begin
            open_win(16);
            for (int a = 0; a < 16; a++) wr(a, $urandom);
        end
        rst = 1'b1; step(); rst = 1'b0;
        step();

        // Underrun after reset
        got_q.delete(); u0 = und_seen;
        repeat (3) tk();
        exp_q = {16'h0000, 16'h0000, 16'h0000};
        cmp_seq("underrun_seq");
        check_val("underrun_cnt", und_seen - u0, 3);

        // Basic fill and playback with saturation
        open_win(4);
        wr(0, 32'h0000_0100); wr(1, 32'h0000_0200); wr(2, 32'hFFFF_FF00); wr(3, 32'h7FFF_FF00);
        u0 = und_seen;
        repeat (4) tk();
        exp_q = {16'h0001, 16'h0002, 16'hFFFF, 16'h7FFF};
        cmp_seq("fill_seq");
        check_val("fill_underrun", und_seen - u0, 0);

        // Ping-pong A (L=3) then B (L=2), sixth tick underruns
        open_win(3); wr(0, 32'h0000_0A00); wr(1, 32'h0000_1400); wr(2, 32'hFFFF_F600);
        open_win(2); wr(0, 32'h8000_0000); wr(1, 32'h0001_0000);
        u0 = und_seen;
        repeat (6) tk();
        exp_q = {16'd10, 16'd20, 16'hFFF6, 16'h8000, 16'd256, 16'h0000};
        cmp_seq("pingpong_seq");
        check_val("pingpong_underrun", und_seen - u0, 1);

        // Overflow with both banks full; stray writes must not corrupt
        open_win(2); wr(0, 32'h0000_0300); wr(1, 32'h0000_0400);
        open_win(2); wr(0, 32'h0000_0500); wr(1, 32'h0000_0600);
        o0 = ovf_seen;
        open_win(2); wr(0, 32'hDEAD_0000); wr(1, 32'hBEEF_0000);
        check_val("overflow_cnt", ovf_seen - o0, 1);
        repeat (5) tk();
        exp_q = {16'd3, 16'd4, 16'd5, 16'd6, 16'h0000};
        cmp_seq("overflow_seq");

        // Boundaries: addr==L ignored, L=0 ignored, commit on last read of the other bank
        open_win(0);
        open_win(3); wr(0, 32'h0000_0700); wr(3, 32'h1234_5600); open_win(0);
        wr(1, 32'h0000_0800); wr(2, 32'h0000_0900);
        u0 = und_seen;
        tk();
        tick = 1'b1; step();
        open_win(2); wr(0, 32'h0000_0A00); step();
        tick = 1'b1; vin = 1'b1; addr = AW'(1); val = 32'h0000_0B00; step();
        repeat (3) step();
        repeat (3) tk();
        exp_q = {16'd7, 16'd8, 16'd9, 16'd10, 16'd11, 16'h0000};
        cmp_seq("seamless_seq");
        check_val("seamless_underrun", und_seen - u0, 1);

        // Reset while playing
        open_win(5);
        for (int a = 0; a < 5; a++) wr(a, 32'((a + 1) * 256));
        tk();
        tick = 1'b1; step();
        rst = 1'b1; step(); rst = 1'b0;
        check_val("rst_playing", {31'd0, playing_out}, 32'd0);
        check_val("rst_sample", {16'd0, sample_out}, 32'd0);
        repeat (3) step();
        u0 = und_seen;
        tk();
        check_val("rst_underrun", und_seen - u0, 1);
        exp_q = {16'd1, 16'h0000};
        cmp_seq("rst_seq");

        // Random traffic against the model
        for (int i = 0; i < 3000; i++) begin
            rst  = ($urandom_range(0, 299) == 0);
            wlv  = ($urandom_range(0, 15) == 0);
            wl   = AW'($urandom_range(0, 6));
            vin  = ($urandom_range(0, 1) == 1);
            addr = AW'($urandom_range(0, 6));
            val  = $urandom;
            tick = (n - last_tick >= 4) && ($urandom_range(0, 2) == 0);
            step();
            rst = 1'b0;
        end
        repeat (4) step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
